// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between the fetch and load/store ports.
// Data requests win conflicts, but only for a bounded burst, so fetch is never starved.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_write,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [31:0]         fetch_stalls
);

  localparam int                BW        = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BW-1:0]     BURST_MAX = BW'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [31:0]   stalls_q, stalls_d;
  logic          burst_full;

  // Grant decision, memory drive and next-state for the issue pipeline.
  always_comb begin
    burst_full = (burst_q == BURST_MAX);
    i_gnt      = !reset && i_req && (!d_req || burst_full);
    d_gnt      = !reset && d_req && !(i_req && burst_full);

    mem_wdata  = d_wdata;
    if (i_gnt) begin
      mem_addr  = i_addr;
      mem_write = '0;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_write = d_we;
    end else begin
      mem_addr  = '0;
      mem_write = '0;
    end

    // Burst count only tracks data grants taken while fetch is waiting.
    if (!i_req || i_gnt) begin
      burst_d = '0;
    end else if (d_gnt && !burst_full) begin
      burst_d = burst_q + 1'b1;
    end else begin
      burst_d = burst_q;
    end

    if (i_gnt) begin
      owner_d = OWN_I;
    end else if (d_gnt && (d_we == '0)) begin
      owner_d = OWN_D;
    end else begin
      owner_d = OWN_NONE;
    end

    if (i_req && !i_gnt) begin
      stalls_d = stalls_q + 32'd1;
    end else begin
      stalls_d = stalls_q;
    end
  end

  // Issue/response state; reset drops any in-flight read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      burst_q  <= '0;
      stalls_q <= 32'd0;
    end else begin
      owner_q  <= owner_d;
      burst_q  <= burst_d;
      stalls_q <= stalls_d;
    end
  end

  assign i_rvalid     = (owner_q == OWN_I);
  assign d_rvalid     = (owner_q == OWN_D);
  assign i_rdata      = mem_rdata;
  assign d_rdata      = mem_rdata;
  assign fetch_stalls = stalls_q;

endmodule
